pc16_rstack: RTL and testbench
==============================

// Module: pc16_rstack
// PURPOSE
//   16-bit program counter with a small hardware return-address stack.
//   Consumes reg16-style load/data semantics and adds increment, jump, call and return.
//   Sits in the fetch stage: q drives the instruction-memory address.
//   Its load path is fed from the ALU/A-register jump target.
// PARAMETERS
//   WIDTH         16       counter and data width
//   DEPTH         4        return-stack entries, >=2
//   RESET_VECTOR  16'h0000 value loaded into q on reset
// PORTS
//   clk    in   1                    clock; all state updates on rising edge
//   rst    in   1                    synchronous reset, active-high
//   ld     in   1                    jump: q <= d
//   inc    in   1                    advance: q <= q + 1
//   call   in   1                    push q+1, then q <= d
//   ret    in   1                    q <= top of stack, pop
//   d      in   WIDTH                jump/call target
//   q      out  WIDTH                current PC, registered
//   depth  out  $clog2(DEPTH+1)      entries on stack, registered
//   empty  out  1                    depth == 0, combinational from depth
//   full   out  1                    depth == DEPTH, combinational from depth
//   err    out  1                    sticky overflow/underflow flag
// BEHAVIOUR
//   - Reset (rst=1 at edge): q=RESET_VECTOR, depth=0, err=0.
//     Stack contents are don't-care. Reset overrides every other input, including mid call/ret.
//   - Per-edge priority when rst=0: ret > call > ld > inc > hold. Exactly one action per cycle.
//   - ret, depth>0: q <= stack[depth-1]; depth <= depth-1.
//   - ret, depth==0: underflow.
//     q holds, depth stays 0, err <= 1.
//     Lower-priority inputs in the same cycle are ignored.
//   - call, depth<DEPTH: stack[depth] <= q+1 (mod 2^WIDTH); q <= d; depth <= depth+1.
//   - call, depth==DEPTH: overflow.
//     q holds, no push, err <= 1.
//     ld/inc in the same cycle are ignored.
//   - call and ret together: ret wins, call is dropped without error.
//     If the stack is empty, the underflow rule applies.
//   - ld: q <= d. Stack untouched.
//   - inc: q <= q+1. Wraps 16'hFFFF -> 16'h0000 with no flag.
//     A call at q=16'hFFFF pushes 16'h0000.
//   - No action asserted: q, depth and stack hold.
//   - Latency: every action is visible on q/depth one cycle after the edge. No combinational path from inputs to q.
//   - err stays 1 until rst. Normal operation continues while err=1.
//   - Stack is LIFO.
//     Entry i is written only by a call at depth==i.
//     ret reads the entry at depth-1.
// TESTING
//   1. rst=1 one edge, then inc=1 for 3 edges -> q 0000,0001,0002,0003; depth=0; empty=1.
//   2. ld=1,d=16'h1234, same cycle inc=1 -> q=1234 (ld beats inc).
//      Next edge inc only -> q=1235.
//   3. q=0010: call d=0100, then call d=0200, then ret, ret.
//      q sequence: 0100, 0200, 0101, 0011.
//      depth sequence: 1, 2, 1, 0.
//   4. Fill 4 calls (full=1), then call d=0BAD -> q unchanged, depth=4, err=1.
//      Then ret -> q = last pushed return address, err still 1.
//   5. depth=0, ret=1 with inc=1 -> q holds, err=1.
//      Next, call=1 and ret=1 with depth=1 -> pop only, depth=0, err unchanged.
//   6. q=FFFF with inc -> 0000.
//      Separately: call at FFFF, then rst mid-sequence (depth=2) -> q=0000, depth=0, err=0 next edge.

Source files
------------

// File: rtl/pc16_rstack.sv
// ============================================================================
//  Module   : pc16_rstack
//  Purpose  : Fetch-stage program counter with a LIFO hardware return stack
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc16_rstack #(
    parameter int                 WIDTH        = 16,
    parameter int                 DEPTH        = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld,
    input  logic                        inc,
    input  logic                        call,
    input  logic                        ret,
    input  logic [WIDTH-1:0]            d,
    output logic [WIDTH-1:0]            q,
    output logic [$clog2(DEPTH+1)-1:0]  depth,
    output logic                        empty,
    output logic                        full,
    output logic                        err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DW-1:0] C_DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] C_ONE       = DW'(1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    sp_q, sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic [WIDTH-1:0] w_pc_inc;
    logic [AW-1:0]    w_push_idx;
    logic [AW-1:0]    w_pop_idx;
    logic             w_push_en;
    logic             w_sp_empty;
    logic             w_sp_full;

    assign w_pc_inc   = pc_q + WIDTH'(1);
    assign w_sp_empty = (sp_q == '0);
    assign w_sp_full  = (sp_q == C_DEPTH_MAX);
    // The push slot index is only used below full, so truncation is safe.
    assign w_push_idx = AW'(sp_q);
    assign w_pop_idx  = AW'(sp_q - C_ONE);

    always_comb begin
        pc_d      = pc_q;
        sp_d      = sp_q;
        err_d     = err_q;
        w_push_en = 1'b0;
        if (ret) begin
            if (!w_sp_empty) begin
                pc_d = stack_q[w_pop_idx];
                sp_d = sp_q - C_ONE;
            end else begin
                err_d = 1'b1;
            end
        end else if (call) begin
            if (!w_sp_full) begin
                w_push_en = 1'b1;
                pc_d      = d;
                sp_d      = sp_q + C_ONE;
            end else begin
                err_d = 1'b1;
            end
        end else if (ld) begin
            pc_d = d;
        end else if (inc) begin
            pc_d = w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage carries no reset; its contents are meaningless below sp_q.
    always_ff @(posedge clk) begin
        if (!rst && w_push_en) begin
            stack_q[w_push_idx] <= w_pc_inc;
        end
    end

    assign q     = pc_q;
    assign depth = sp_q;
    assign empty = w_sp_empty;
    assign full  = w_sp_full;
    assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc16_rstack.sv
// ============================================================================
//  Module   : tb_pc16_rstack
//  Purpose  : Directed self-checking bench for pc16_rstack
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc16_rstack;

    logic        clk;
    logic        rst;
    logic        ld;
    logic        inc;
    logic        call;
    logic        ret;
    logic [15:0] d;
    logic [15:0] q;
    logic [2:0]  depth;
    logic        empty;
    logic        full;
    logic        err;

    int n_vec;
    int n_err;

    pc16_rstack #(
        .WIDTH        (16),
        .DEPTH        (4),
        .RESET_VECTOR (16'h0000)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .ld    (ld),
        .inc   (inc),
        .call  (call),
        .ret   (ret),
        .d     (d),
        .q     (q),
        .depth (depth),
        .empty (empty),
        .full  (full),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i_rst, input logic i_ld, input logic i_inc,
                         input logic i_call, input logic i_ret, input logic [15:0] i_d);
        rst  = i_rst;
        ld   = i_ld;
        inc  = i_inc;
        call = i_call;
        ret  = i_ret;
        d    = i_d;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] eq, input logic [2:0] ed,
                             input logic ee);
        chk({tag, ".q"},     32'(q),     32'(eq));
        chk({tag, ".depth"}, 32'(depth), 32'(ed));
        chk({tag, ".empty"}, 32'(empty), 32'(ed == 3'd0));
        chk({tag, ".full"},  32'(full),  32'(ed == 3'd4));
        chk({tag, ".err"},   32'(err),   32'(ee));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset then increment
        drive(1, 0, 0, 0, 0, 16'h0000); tick(); chk_state("rst", 16'h0000, 0, 0);
        drive(0, 0, 1, 0, 0, 16'h0000); tick(); chk_state("inc1", 16'h0001, 0, 0);
        tick(); chk_state("inc2", 16'h0002, 0, 0);
        tick(); chk_state("inc3", 16'h0003, 0, 0);

        // ld beats inc
        drive(0, 1, 1, 0, 0, 16'h1234); tick(); chk_state("ld_inc", 16'h1234, 0, 0);
        drive(0, 0, 1, 0, 0, 16'h0000); tick(); chk_state("inc_after_ld", 16'h1235, 0, 0);
        drive(0, 0, 0, 0, 0, 16'hDEAD); tick(); chk_state("hold", 16'h1235, 0, 0);

        // Nested call/return
        drive(0, 1, 0, 0, 0, 16'h0010); tick(); chk_state("ld10", 16'h0010, 0, 0);
        drive(0, 0, 0, 1, 0, 16'h0100); tick(); chk_state("call1", 16'h0100, 1, 0);
        drive(0, 0, 0, 1, 0, 16'h0200); tick(); chk_state("call2", 16'h0200, 2, 0);
        drive(0, 0, 0, 0, 1, 16'h0000); tick(); chk_state("ret1", 16'h0101, 1, 0);
        tick(); chk_state("ret2", 16'h0011, 0, 0);

        // Fill, overflow, drain
        drive(0, 0, 0, 1, 0, 16'hA000); tick(); chk_state("fill1", 16'hA000, 1, 0);
        drive(0, 0, 0, 1, 0, 16'hA100); tick(); chk_state("fill2", 16'hA100, 2, 0);
        drive(0, 0, 0, 1, 0, 16'hA200); tick(); chk_state("fill3", 16'hA200, 3, 0);
        drive(0, 0, 0, 1, 0, 16'hA300); tick(); chk_state("fill4", 16'hA300, 4, 0);
        drive(0, 1, 1, 1, 0, 16'h0BAD); tick(); chk_state("ovf", 16'hA300, 4, 1);
        drive(0, 0, 0, 0, 1, 16'h0000); tick(); chk_state("drain1", 16'hA201, 3, 1);
        tick(); chk_state("drain2", 16'hA101, 2, 1);
        tick(); chk_state("drain3", 16'hA001, 1, 1);
        tick(); chk_state("drain4", 16'h0012, 0, 1);

        // Underflow with inc ignored, then call+ret pops without error
        drive(1, 0, 0, 0, 0, 16'h0000); tick(); chk_state("rst2", 16'h0000, 0, 0);
        drive(0, 0, 1, 0, 1, 16'h0000); tick(); chk_state("udf", 16'h0000, 0, 1);
        drive(0, 0, 0, 1, 0, 16'h0300); tick(); chk_state("call_e1", 16'h0300, 1, 1);
        drive(0, 0, 0, 1, 1, 16'h0400); tick(); chk_state("callret_e1", 16'h0001, 0, 1);
        drive(1, 0, 0, 0, 0, 16'h0000); tick(); chk_state("rst3", 16'h0000, 0, 0);
        drive(0, 0, 0, 1, 0, 16'h0300); tick(); chk_state("call_e0", 16'h0300, 1, 0);
        drive(0, 0, 0, 1, 1, 16'h0400); tick(); chk_state("callret_e0", 16'h0001, 0, 0);

        // Wrap on inc and on call's return address
        drive(0, 1, 0, 0, 0, 16'hFFFF); tick(); chk_state("ldFFFF", 16'hFFFF, 0, 0);
        drive(0, 0, 1, 0, 0, 16'h0000); tick(); chk_state("inc_wrap", 16'h0000, 0, 0);
        drive(0, 1, 0, 0, 0, 16'hFFFF); tick();
        drive(0, 0, 0, 1, 0, 16'h0500); tick(); chk_state("call_wrap", 16'h0500, 1, 0);
        drive(0, 0, 0, 0, 1, 16'h0000); tick(); chk_state("ret_wrap", 16'h0000, 0, 0);

        // Reset mid-sequence with err set and stack at depth 2
        drive(0, 0, 0, 0, 1, 16'h0000); tick(); chk_state("udf2", 16'h0000, 0, 1);
        drive(0, 1, 0, 0, 0, 16'hFFFF); tick();
        drive(0, 0, 0, 1, 0, 16'h0500); tick(); chk_state("mid_call1", 16'h0500, 1, 1);
        drive(0, 0, 0, 1, 0, 16'h0600); tick(); chk_state("mid_call2", 16'h0600, 2, 1);
        drive(1, 1, 1, 1, 0, 16'h0700); tick(); chk_state("rst_mid", 16'h0000, 0, 0);
        drive(0, 0, 0, 0, 1, 16'h0000); tick(); chk_state("udf_after_rst", 16'h0000, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
